instruction_fetch: RTL

Front-end fetch stage of the RISC-V core. Owns the program counter, issues word reads to instruction memory over a valid/ready request channel, and buffers returned words in a small in-order queue. Presents one 32-bit instruction plus its PC per handshake to the downstream field parser. Supports a single-cycle redirect (branch/jump) that flushes all buffered and in-flight fetches.

---
 rtl/instruction_fetch.sv | 120 ++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues credit-limited imem reads, queues returned words in order; FETCH_ALIGN_CHECK_EN enables misaligned-redirect detection.
// Latency: response at edge N -> inst_valid in cycle N+1 (registered queue, no bypass).
// Backpressure: requests stall while queued + in-flight reach DEPTH; redirect flushes the queue and drops stale responses.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc,
  output logic        fetch_misaligned
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } fetch_entry_t;

  fetch_entry_t  q_mem [DEPTH];
  logic [AW-1:0] q_wp, q_rp;
  logic [CW-1:0] q_count;
  logic [CW-1:0] inflight, inflight_nxt, drop;
  logic [31:0]   pc, resp_pc, target_pc;
  logic [CW:0]   occupancy;
  logic          req_fire, resp_stale, push, pop;

  // Stale responses still occupy credit, so they count until they return.
  assign occupancy      = {1'b0, q_count} + {1'b0, inflight};
  assign imem_req_valid = !reset && !redirect_valid && (occupancy < DEPTH_C);
  assign imem_addr      = {pc[31:2], 2'b00};
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_stale = (drop != '0);
  assign push       = imem_resp_valid && !resp_stale && !redirect_valid;
  assign pop        = inst_valid && inst_ready && !redirect_valid;

  assign inst_valid  = (q_count != '0);
  assign instruction = q_mem[q_rp].word;
  assign inst_pc     = q_mem[q_rp].pc;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misaligned_q;

  assign target_pc        = {redirect_pc[31:2], 2'b00};
  assign fetch_misaligned = misaligned_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) misaligned_q <= 1'b0;
    else       misaligned_q <= redirect_valid && (redirect_pc[1:0] != 2'b00);
  end
`else
  assign target_pc        = redirect_pc;
  assign fetch_misaligned = 1'b0;
`endif

  always_comb begin
    inflight_nxt = inflight;
    if (req_fire && !imem_resp_valid)      inflight_nxt = inflight + CW'(1);
    else if (!req_fire && imem_resp_valid) inflight_nxt = inflight - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (redirect_valid) begin
        // Everything still outstanding after this edge belongs to the old path.
        pc      <= target_pc;
        resp_pc <= target_pc;
        drop    <= inflight_nxt;
      end else begin
        if (req_fire) pc <= pc + 32'd4;
        if (push) resp_pc <= resp_pc + 32'd4;
        if (imem_resp_valid && resp_stale) drop <= drop - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_wp    <= '0;
      q_rp    <= '0;
      q_count <= '0;
      for (int i = 0; i < DEPTH; i++) q_mem[i] <= '0;
    end else if (redirect_valid) begin
      q_wp    <= '0;
      q_rp    <= '0;
      q_count <= '0;
    end else begin
      if (push) begin
        q_mem[q_wp] <= '{word: imem_resp_data, pc: resp_pc};
        q_wp        <= q_wp + AW'(1);
      end
      if (pop) q_rp <= q_rp + AW'(1);
      case ({push, pop})
        2'b10:   q_count <= q_count + CW'(1);
        2'b01:   q_count <= q_count - CW'(1);
        default: q_count <= q_count;
      endcase
    end
  end

endmodule
